// File: rtl/zassenhaus_reduce_pkg.sv
// Shared FSM encodings, CLOG2 helper and default sizes for the Zassenhaus reducer.
`define CLOG2(x) (((x) <= 2) ? 1 : $clog2(x))

package zassenhaus_reduce_pkg;
  localparam int N_DEF    = 47;
  localparam int M_DEF    = 79;
  localparam int ROWS_DEF = 2 * N_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SWAP,
    ST_ELIM,
    ST_NEXT,
    ST_EXTRACT,
    ST_DONE
  } state_e;

  // Sub-step of one memory row access: address, wait for data, then up to two writes.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT,
    PH_WR0,
    PH_WR1
  } phase_e;
endpackage

// File: rtl/zassenhaus_reduce_if.sv
// Memory-side bus of the reducer: S1S2 row RAM port plus basis (E) write port.
interface zassenhaus_reduce_if #(
  parameter int m  = 79,
  parameter int AW = 7,
  parameter int EW = 6
);
  logic [2*m-1:0] S1S2_din;
  logic [2*m-1:0] S1S2_dout;
  logic [AW-1:0]  S1S2_addr;
  logic           S1S2_rw;
  logic [m-1:0]   E_dout;
  logic [EW-1:0]  E_addr;
  logic           E_rw;

  modport master (
    input  S1S2_din,
    output S1S2_dout, S1S2_addr, S1S2_rw, E_dout, E_addr, E_rw
  );

  modport slave (
    output S1S2_din,
    input  S1S2_dout, S1S2_addr, S1S2_rw, E_dout, E_addr, E_rw
  );
endinterface

// File: rtl/zassenhaus_reduce_pivot.sv
// Pivot register P with the column-bit test and XOR elimination datapath (combinational from row_i).
module zr_pivot_row #(
  parameter int W  = 158,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          load_i,
  input  logic [W-1:0]  row_i,
  input  logic [CW-1:0] col_i,
  output logic [W-1:0]  p_o,
  output logic          hit_o,
  output logic [W-1:0]  xor_o
);
  logic [W-1:0] p_q;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      p_q <= '0;
    end else if (load_i) begin
      p_q <= row_i;
    end
  end

  assign p_o   = p_q;
  assign hit_o = row_i[col_i];
  assign xor_o = row_i ^ p_q;
endmodule

// File: rtl/zassenhaus_reduce.sv
// In-place GF(2) echelon reduction of [U|U ; V|0], then emits the basis of U∩V; one row access at a time.
// Define ZR_RREF_EN to also clear rows above each pivot (reduced row-echelon form, reduced basis).
module zassenhaus_reduce
  import zassenhaus_reduce_pkg::*;
#(
  parameter int n        = N_DEF,
  parameter int m        = M_DEF,
  parameter int ROWS     = 2 * n,
  parameter int DELAY_rd = 1
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  output logic                   finish,
  output logic [`CLOG2(n+1)-1:0] dim,
  zassenhaus_reduce_if.master    mem
);
  localparam int W   = 2 * m;
  localparam int AW  = `CLOG2(ROWS);
  localparam int RCW = `CLOG2(ROWS + 1);
  localparam int CW  = `CLOG2(W);
  localparam int DW  = `CLOG2(n + 1);
  localparam int EW  = `CLOG2(n);
  localparam int WCW = `CLOG2(DELAY_rd + 1);

  localparam logic [RCW-1:0] ROWS_C   = RCW'(ROWS);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);
  localparam logic [WCW-1:0] DLY      = WCW'(DELAY_rd);

`ifdef ZR_RREF_EN
  localparam bit RREF = 1'b1;
`else
  localparam bit RREF = 1'b0;
`endif

  state_e           state_q;
  phase_e           phase_q;
  logic [CW-1:0]    col_q;
  logic [RCW-1:0]   pr_q, pa_q, r_q;
  logic [WCW-1:0]   wcnt_q;
  logic             found_q;
  logic [W-1:0]     t_q;
  logic [DW-1:0]    cnt_q, dim_q;
  logic [AW-1:0]    addr_q;
  logic             rw_q, e_rw_q, finish_q;
  logic [W-1:0]     dout_q;
  logic [m-1:0]     e_dout_q;
  logic [EW-1:0]    e_addr_q;

  logic [W-1:0]     din, p_row, x_row;
  logic             hit, data_ok, piv_load, basis_row;
  logic [RCW-1:0]   pr_d;
  logic [DW-1:0]    cnt_d;

  assign din       = mem.S1S2_din;
  assign data_ok   = (phase_q == PH_WAIT) && (wcnt_q == '0);
  assign piv_load  = (state_q == ST_SCAN) && data_ok && hit;
  assign pr_d      = pr_q + RCW'(found_q);
  assign basis_row = (din[W-1:m] == '0) && (din[m-1:0] != '0);
  assign cnt_d     = cnt_q + DW'(basis_row);

  zr_pivot_row #(.W(W), .CW(CW)) u_pivot (
    .clk    (clk),
    .rst_b  (rst_b),
    .load_i (piv_load),
    .row_i  (din),
    .col_i  (col_q),
    .p_o    (p_row),
    .hit_o  (hit),
    .xor_o  (x_row)
  );

  // Elimination row walk: below the pivot only, or every row except the pivot in RREF mode.
  function automatic logic [RCW-1:0] elim_first(input logic [RCW-1:0] p);
    if (RREF) return (p == '0) ? RCW'(1) : '0;
    return p + RCW'(1);
  endfunction

  function automatic logic [RCW-1:0] elim_next(input logic [RCW-1:0] r, input logic [RCW-1:0] p);
    logic [RCW-1:0] c;
    c = r + RCW'(1);
    if (RREF && (c == p)) c = c + RCW'(1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_ISSUE;
      col_q    <= '0;
      pr_q     <= '0;
      pa_q     <= '0;
      r_q      <= '0;
      wcnt_q   <= '0;
      found_q  <= 1'b0;
      t_q      <= '0;
      cnt_q    <= '0;
      dim_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      dout_q   <= '0;
      e_rw_q   <= 1'b0;
      e_dout_q <= '0;
      e_addr_q <= '0;
      finish_q <= 1'b0;
    end else begin
      rw_q     <= 1'b0;
      dout_q   <= '0;
      e_rw_q   <= 1'b0;
      e_dout_q <= '0;
      finish_q <= 1'b0;
      if (phase_q == PH_WAIT && wcnt_q != '0) begin
        wcnt_q <= wcnt_q - WCW'(1);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_SCAN;
              phase_q <= PH_ISSUE;
              col_q   <= CW'(W - 1);
              pr_q    <= '0;
              r_q     <= '0;
              found_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
          ST_SCAN: begin
            if (phase_q == PH_ISSUE) begin
              addr_q  <= r_q[AW-1:0];
              wcnt_q  <= DLY;
              phase_q <= PH_WAIT;
            end else if (hit) begin
              found_q <= 1'b1;
              pa_q    <= r_q;
              phase_q <= PH_ISSUE;
              if (r_q != pr_q) begin
                state_q <= ST_SWAP;
              end else begin
                state_q <= ST_ELIM;
                r_q     <= elim_first(pr_q);
              end
            end else if (r_q == LAST_ROW) begin
              state_q <= ST_NEXT;
            end else begin
              r_q     <= r_q + RCW'(1);
              phase_q <= PH_ISSUE;
            end
          end
          ST_SWAP: begin
            case (phase_q)
              PH_ISSUE: begin
                addr_q  <= pr_q[AW-1:0];
                wcnt_q  <= DLY;
                phase_q <= PH_WAIT;
              end
              PH_WAIT: begin
                t_q     <= din;
                phase_q <= PH_WR0;
              end
              PH_WR0: begin
                addr_q  <= pr_q[AW-1:0];
                rw_q    <= 1'b1;
                dout_q  <= p_row;
                phase_q <= PH_WR1;
              end
              default: begin
                addr_q  <= pa_q[AW-1:0];
                rw_q    <= 1'b1;
                dout_q  <= t_q;
                state_q <= ST_ELIM;
                phase_q <= PH_ISSUE;
                r_q     <= elim_first(pr_q);
              end
            endcase
          end
          ST_ELIM: begin
            case (phase_q)
              PH_ISSUE: begin
                if (r_q >= ROWS_C) begin
                  state_q <= ST_NEXT;
                end else begin
                  addr_q  <= r_q[AW-1:0];
                  wcnt_q  <= DLY;
                  phase_q <= PH_WAIT;
                end
              end
              PH_WAIT: begin
                if (hit) begin
                  rw_q    <= 1'b1;
                  dout_q  <= x_row;
                  phase_q <= PH_WR0;
                end else begin
                  r_q     <= elim_next(r_q, pr_q);
                  phase_q <= PH_ISSUE;
                end
              end
              default: begin
                r_q     <= elim_next(r_q, pr_q);
                phase_q <= PH_ISSUE;
              end
            endcase
          end
          ST_NEXT: begin
            pr_q    <= pr_d;
            found_q <= 1'b0;
            phase_q <= PH_ISSUE;
            if (col_q == '0 || pr_d == ROWS_C) begin
              state_q <= ST_EXTRACT;
              r_q     <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_SCAN;
              col_q   <= col_q - CW'(1);
              r_q     <= pr_d;
            end
          end
          ST_EXTRACT: begin
            if (phase_q == PH_ISSUE) begin
              addr_q  <= r_q[AW-1:0];
              wcnt_q  <= DLY;
              phase_q <= PH_WAIT;
            end else begin
              if (basis_row) begin
                e_rw_q   <= 1'b1;
                e_dout_q <= din[m-1:0];
                e_addr_q <= cnt_q[EW-1:0];
              end
              cnt_q <= cnt_d;
              if (r_q == LAST_ROW) begin
                state_q  <= ST_DONE;
                dim_q    <= cnt_d;
                finish_q <= 1'b1;
              end else begin
                r_q     <= r_q + RCW'(1);
                phase_q <= PH_ISSUE;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
          end
        endcase
      end
    end
  end

  assign finish         = finish_q;
  assign dim            = dim_q;
  assign mem.S1S2_dout  = dout_q;
  assign mem.S1S2_addr  = addr_q;
  assign mem.S1S2_rw    = rw_q;
  assign mem.E_dout     = e_dout_q;
  assign mem.E_addr     = e_addr_q;
  assign mem.E_rw       = e_rw_q;
endmodule

// File: tb/tb_zassenhaus_reduce.sv
// Directed bench for zassenhaus_reduce with n=2, m=4, two-cycle read latency memory model.
module tb_zassenhaus_reduce;
  import zassenhaus_reduce_pkg::*;

  localparam int N   = 2;
  localparam int M   = 4;
  localparam int R   = 2 * N;
  localparam int DLY = 2;

`ifdef ZR_RREF_EN
  localparam int          S1_WRITES = 8;
  localparam logic [7:0]  S1_M0 = 8'h20;
  localparam logic [7:0]  S1_M1 = 8'h10;
`else
  localparam int          S1_WRITES = 6;
  localparam logic [7:0]  S1_M0 = 8'h22;
  localparam logic [7:0]  S1_M1 = 8'h11;
`endif

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic       finish;
  logic [1:0] dim;

  zassenhaus_reduce_if #(.m(M), .AW(2), .EW(1)) bus ();

  zassenhaus_reduce #(.n(N), .m(M), .ROWS(R), .DELAY_rd(DLY)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .finish (finish),
    .dim    (dim),
    .mem    (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [R];
  logic [7:0] rd_pipe [DLY];
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_dat;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_dat;
    else if (bus.S1S2_rw) mem[bus.S1S2_addr] <= bus.S1S2_dout;
    rd_pipe[0] <= mem[bus.S1S2_addr];
    for (int i = 1; i < DLY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.S1S2_din = rd_pipe[DLY-1];

  int         fin_cnt = 0;
  int         quiet_viol = 0;
  logic [1:0] wr_addr [$];
  logic [7:0] wr_dat [$];
  logic [3:0] e_dat [$];
  logic       e_adr [$];

  always @(negedge clk) begin
    if (finish) fin_cnt++;
    if (bus.S1S2_rw) begin
      wr_addr.push_back(bus.S1S2_addr);
      wr_dat.push_back(bus.S1S2_dout);
    end
    if (bus.E_rw) begin
      e_dat.push_back(bus.E_dout);
      e_adr.push_back(bus.E_addr);
    end
    if (!bus.S1S2_rw && bus.S1S2_dout != '0) quiet_viol++;
    if (!bus.E_rw && bus.E_dout != '0) quiet_viol++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    logic [7:0] v [4];
    v = '{r0, r1, r2, r3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 2'(i);
      ld_dat  = v[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_finish(input int f0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fin_cnt != f0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_rw"},     32'(bus.S1S2_rw), 32'd0);
    chk({tag, "_dout"},   32'(bus.S1S2_dout), 32'd0);
    chk({tag, "_addr"},   32'(bus.S1S2_addr), 32'd0);
    chk({tag, "_erw"},    32'(bus.E_rw), 32'd0);
    chk({tag, "_edout"},  32'(bus.E_dout), 32'd0);
    chk({tag, "_eaddr"},  32'(bus.E_addr), 32'd0);
    chk({tag, "_dim"},    32'(dim), 32'd0);
  endtask

  task automatic check_s1_basis(input string tag, input int f0, input int e0);
    chk({tag, "_fin"},  32'(fin_cnt - f0), 32'd1);
    chk({tag, "_dim"},  32'(dim), 32'd2);
    chk({tag, "_ecnt"}, 32'(e_dat.size() - e0), 32'd2);
    chk({tag, "_e0"},   32'(e_dat[e0]), 32'h2);
    chk({tag, "_e1"},   32'(e_dat[e0+1]), 32'h1);
    chk({tag, "_ea0"},  32'(e_adr[e0]), 32'd0);
    chk({tag, "_ea1"},  32'(e_adr[e0+1]), 32'd1);
  endtask

  initial begin
    bit ok;
    int f0, w0, e0;
    rst_b = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_dat = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_b = 1'b0;

    // U={0001,0010}, V={0001,0010}: full intersection, two swaps along the way.
    load(8'h11, 8'h22, 8'h10, 8'h20);
    f0 = fin_cnt; w0 = wr_dat.size(); e0 = e_dat.size();
    pulse_start();
    wait_finish(f0, ok);
    chk("s1_done", 32'(ok), 32'd1);
    check_s1_basis("s1", f0, e0);
    chk("s1_writes", 32'(wr_dat.size() - w0), 32'(S1_WRITES));
    chk("s1_swap_a0", 32'(wr_addr[w0]), 32'd0);
    chk("s1_swap_d0", 32'(wr_dat[w0]), 32'h22);
    chk("s1_swap_a1", 32'(wr_addr[w0+1]), 32'd1);
    chk("s1_swap_d1", 32'(wr_dat[w0+1]), 32'h11);
    chk("s1_elim_a",  32'(wr_addr[w0+2]), 32'd3);
    chk("s1_elim_d",  32'(wr_dat[w0+2]), 32'h02);
    chk("s1_mem0", 32'(mem[0]), 32'(S1_M0));
    chk("s1_mem1", 32'(mem[1]), 32'(S1_M1));
    chk("s1_mem2", 32'(mem[2]), 32'h02);
    chk("s1_mem3", 32'(mem[3]), 32'h01);

    // Reset while eliminating: outputs clear on the next edge, no further writes.
    load(8'h11, 8'h22, 8'h10, 8'h20);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dut.state_q == ST_ELIM) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reach_elim", 32'(ok), 32'd1);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("rst_mid");
    w0 = wr_dat.size();
    repeat (3) @(negedge clk);
    chk("rst_no_writes", 32'(wr_dat.size() - w0), 32'd0);
    rst_b = 1'b0;
    load(8'h11, 8'h22, 8'h10, 8'h20);
    f0 = fin_cnt; e0 = e_dat.size();
    pulse_start();
    wait_finish(f0, ok);
    chk("rst_rerun_done", 32'(ok), 32'd1);
    check_s1_basis("rst_rerun", f0, e0);

    // U={0001,0010}, V={0100,1000}: trivial intersection.
    load(8'h11, 8'h22, 8'h40, 8'h80);
    f0 = fin_cnt; w0 = wr_dat.size(); e0 = e_dat.size();
    pulse_start();
    wait_finish(f0, ok);
    chk("s2_done", 32'(ok), 32'd1);
    chk("s2_fin",  32'(fin_cnt - f0), 32'd1);
    chk("s2_dim",  32'(dim), 32'd0);
    chk("s2_ecnt", 32'(e_dat.size() - e0), 32'd0);
    chk("s2_writes", 32'(wr_dat.size() - w0), 32'd4);
    chk("s2_swap_a0", 32'(wr_addr[w0]), 32'd0);
    chk("s2_swap_d0", 32'(wr_dat[w0]), 32'h80);
    chk("s2_swap_a1", 32'(wr_addr[w0+1]), 32'd3);
    chk("s2_swap_d1", 32'(wr_dat[w0+1]), 32'h11);

    // All-zero matrix.
    load(8'h00, 8'h00, 8'h00, 8'h00);
    f0 = fin_cnt; w0 = wr_dat.size(); e0 = e_dat.size();
    pulse_start();
    wait_finish(f0, ok);
    chk("s3_done", 32'(ok), 32'd1);
    chk("s3_fin",  32'(fin_cnt - f0), 32'd1);
    chk("s3_dim",  32'(dim), 32'd0);
    chk("s3_writes", 32'(wr_dat.size() - w0), 32'd0);
    chk("s3_ecnt", 32'(e_dat.size() - e0), 32'd0);

    // Second start during SCAN must be ignored.
    load(8'h11, 8'h22, 8'h10, 8'h20);
    f0 = fin_cnt; e0 = e_dat.size();
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(f0, ok);
    chk("s6_done", 32'(ok), 32'd1);
    repeat (200) @(negedge clk);
    check_s1_basis("s6", f0, e0);

    chk("quiet_outputs", 32'(quiet_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
